disp_share_sched: RTL and testbench
===================================

// Module: disp_share_sched
// PURPOSE
//   Scan scheduler and two-requester arbiter for the shared 8-digit 7-segment display.
//   Requester A (high priority) and requester B each offer a 32-bit frame of 8 hex digits.
//   The block grants one owner, latches its frame and drives the digit scan.
//   Outputs per digit: anode select and a 4-bit nibble for the 7-segment decoder.
//   Enforces a minimum display hold time before the owner can change.
// PARAMETERS
//   SCAN_DIV    100000  clk cycles per digit slot (>=2)
//   HOLD_FRAMES 64      full 8-digit scans a grant is shown before re-arbitration (>=1)
// PORTS
//   clk        in   1   system clock, the only clock
//   rst        in   1   synchronous reset, active-high
//   req_a      in   1   A requests display; held high until ack_a
//   data_a     in   32  A frame; nibble i -> digit i (digit 0 = rightmost, an[0])
//   ack_a      out  1   1-cycle pulse: A granted, data_a latched
//   req_b      in   1   B request, same rules as A
//   data_b     in   32  B frame
//   ack_b      out  1   1-cycle grant pulse for B
//   blank_lz   in   1   1 = blank leading-zero digits
//   an         out  8   digit enables, active-low, one-hot-low while showing
//   digit      out  4   nibble of the active digit, to the decoder
//   owner      out  2   00 none, 01 A, 10 B
//   frame_done out  1   1-cycle pulse at the end of each full 8-digit scan
// BEHAVIOUR
//   Reset values: an=8'hFF, digit=0, owner=00, ack_a=ack_b=0, frame_done=0.
//     Internal: prescaler=0, idx=0, hold=0, frame=0, FSM=IDLE.
//   All outputs are registered; rst mid-operation forces reset values at the next edge.
//   Prescaler counts 0..SCAN_DIV-1 and wraps; a step occurs on the cycle it reads SCAN_DIV-1.
//   On step, idx advances mod 8 (7->0 wrap); frame_done=1 on the step that wraps 7->0.
//   Prescaler and idx run only when owner!=00.
//   FSM states:
//     IDLE -> SHOW_A if req_a, else -> SHOW_B if req_b.
//       Evaluated on every cycle; A wins ties.
//     SHOW_x, on a frame_done cycle: hold increments, saturating at HOLD_FRAMES.
//       Once hold (incl. this increment) >= HOLD_FRAMES: re-arbitrate at this edge.
//       Re-arbitration: A wins, else B; this includes re-granting the current owner.
//       No request pending -> stay in SHOW_x showing the latched frame; no ack.
//     No other transitions; the owner never returns to IDLE except via rst.
//   Grant edge: frame<=data_x; ack_x=1 for exactly the next cycle; owner updated.
//     Also on the grant edge: hold, prescaler and idx cleared to 0.
//     Output latency: the cycle after the grant shows an=8'hFE, digit=frame[3:0].
//   A request dropped before its ack is withdrawn; no ack is ever issued for it.
//   While requesting, data_x must be stable; only the value on the grant edge matters.
//   an[idx]=0, all other bits=1; digit=frame[4*idx+3:4*idx].
//     While owner=00: an=8'hFF, digit=0.
//   Leading-zero blanking: with blank_lz=1, let m = index of the highest nonzero nibble (m=0 if frame==0).
//     For idx>m, an stays 8'hFF for that slot and timing is unchanged. Digit 0 is never blanked.
//     blank_lz is sampled every cycle.
// TESTING (SCAN_DIV=4, HOLD_FRAMES=2)
//   1 Reset: rst=1 for 2 cycles with req_a=1 -> an=FF, digit=0, owner=00, no ack.
//       After rst falls, ack_a is seen 1 cycle later.
//   2 req_b=1, data_b=32'h12345678 from IDLE -> ack_b pulses one cycle; owner=10.
//       Then an=FE/digit=8 for 4 cycles, FD/7, ... 7F/1.
//       frame_done at cycle 32 after the grant; then digit 0 repeats.
//   3 req_a and req_b rise together in IDLE -> A granted, B waits.
//       At the 2nd frame_done, ack_b pulses and owner=10.
//   4 B owns; req_a rises mid first frame -> no ack_a at the 1st frame_done.
//       ack_a at the 2nd frame_done; A preempts even though req_b is re-asserted.
//   5 blank_lz=1, frame 32'h00000A05 -> slots 0,1,2 show 5,0,A; slots 3..7 give an=FF.
//       blank_lz=0 -> all 8 digits are enabled.
//   6 req_b withdrawn before its grant edge -> never acked.
//       rst mid-scan while owner=01 -> reset values at the next cycle.

Source files
------------

// File: rtl/disp_share_sched.sv
// disp_share_sched: two-requester arbiter and digit scan scheduler for a shared
// 8-digit 7-segment display.
//   clk, rst           : clock, synchronous active-high reset
//   req_a/data_a/ack_a : high-priority requester (frame in, 1-cycle grant pulse out)
//   req_b/data_b/ack_b : low-priority requester
//   blank_lz           : blank leading-zero digits above the highest nonzero nibble
//   an, digit          : active-low digit enables and nibble of the active digit
//   owner              : 00 none, 01 A, 10 B
//   frame_done         : 1-cycle pulse at the end of each full 8-digit scan
module disp_share_sched #(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned HOLD_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [31:0] data_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [31:0] data_b,
  output logic        ack_b,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [3:0]  digit,
  output logic [1:0]  owner,
  output logic        frame_done
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW_A, ST_SHOW_B} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [31:0]   frame_q, frame_d;
  logic          ack_a_q, ack_a_d;
  logic          ack_b_q, ack_b_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    an_q, an_d;
  logic [3:0]    digit_q, digit_d;
  logic [1:0]    owner_q, owner_d;
  logic          grant_a, grant_b;
  logic [2:0]    lz_top;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      idx_q        <= '0;
      hold_q       <= '0;
      frame_q      <= '0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= 8'hFF;
      digit_q      <= 4'd0;
      owner_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      frame_q      <= frame_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      digit_q      <= digit_d;
      owner_q      <= owner_d;
    end
  end

  // Arbitration, scan stepping and next-cycle display outputs
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    frame_d      = frame_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    frame_done_d = 1'b0;
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    owner_d      = 2'b00;
    an_d         = 8'hFF;
    digit_d      = 4'd0;
    lz_top       = 3'd0;

    case (state_q)
      ST_IDLE: begin
        if (req_a)      grant_a = 1'b1;
        else if (req_b) grant_b = 1'b1;
      end
      default: begin
        if (presc_q == PW'(SCAN_DIV - 1)) begin
          presc_d = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            frame_done_d = 1'b1;
            // Saturate so an idle hold keeps re-arbitrating at each frame end
            hold_d = (hold_q >= HW'(HOLD_FRAMES)) ? hold_q : hold_q + HW'(1);
            if (hold_d >= HW'(HOLD_FRAMES)) begin
              if (req_a)      grant_a = 1'b1;
              else if (req_b) grant_b = 1'b1;
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    endcase

    if (grant_a) begin
      state_d = ST_SHOW_A;
      frame_d = data_a;
      ack_a_d = 1'b1;
    end else if (grant_b) begin
      state_d = ST_SHOW_B;
      frame_d = data_b;
      ack_b_d = 1'b1;
    end
    if (grant_a || grant_b) begin
      hold_d  = '0;
      presc_d = '0;
      idx_d   = '0;
    end

    case (state_d)
      ST_SHOW_A: owner_d = 2'b01;
      ST_SHOW_B: owner_d = 2'b10;
      default:   owner_d = 2'b00;
    endcase

    // Highest nonzero nibble; digit 0 always stays visible
    for (int i = 1; i < 8; i++) begin
      if (frame_d[4*i +: 4] != 4'd0) lz_top = 3'(i);
    end

    if (owner_d != 2'b00) begin
      digit_d = frame_d[4*idx_d +: 4];
      if (!(blank_lz && (idx_d > lz_top))) an_d = ~(8'd1 << idx_d);
    end
  end

  assign ack_a      = ack_a_q;
  assign ack_b      = ack_b_q;
  assign frame_done = frame_done_q;
  assign an         = an_q;
  assign digit      = digit_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_disp_share_sched.sv
// Directed bench for disp_share_sched with SCAN_DIV=4, HOLD_FRAMES=2.
module tb_disp_share_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b, blank_lz;
  logic [31:0] data_a, data_b;
  logic        ack_a, ack_b, frame_done;
  logic [7:0]  an;
  logic [3:0]  digit;
  logic [1:0]  owner;

  int vectors = 0;
  int errors  = 0;

  disp_share_sched #(.SCAN_DIV(4), .HOLD_FRAMES(2)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
    .blank_lz(blank_lz), .an(an), .digit(digit),
    .owner(owner), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Advance one edge, then settle before sampling and driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; blank_lz = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = 1'b1; req_b = 1'b0; blank_lz = 1'b0;
    data_a = 32'hCAFE0001; data_b = 32'h0;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if ({an, digit, owner, ack_a, ack_b, frame_done} !== {8'hFF, 4'd0, 2'b00, 3'b000}) begin
        errors++;
        $display("FAIL reset_state c=%0d: an=%h digit=%h owner=%b ack=%b%b fd=%b",
                 c, an, digit, owner, ack_a, ack_b, frame_done);
      end
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({ack_a, owner, an, digit} !== {1'b1, 2'b01, 8'hFE, 4'h1}) begin
      errors++;
      $display("FAIL reset_first_grant: ack_a=%b owner=%b an=%h digit=%h want 1 01 fe 1",
               ack_a, owner, an, digit);
    end
    req_a = 1'b0;
    tick();
    vectors++;
    if (ack_a !== 1'b0) begin
      errors++;
      $display("FAIL ack_a_pulse_width: ack_a=%b want 0", ack_a);
    end
  endtask

  task automatic test_scan_b();
    logic [31:0] f;
    int idx;
    f = 32'h12345678;
    do_reset();
    req_b = 1'b1; data_b = f;
    tick();
    vectors++;
    if ({ack_b, ack_a, owner, an, digit, frame_done} !== {1'b1, 1'b0, 2'b10, 8'hFE, 4'h8, 1'b0}) begin
      errors++;
      $display("FAIL scan_b_grant: ack_b=%b ack_a=%b owner=%b an=%h digit=%h fd=%b",
               ack_b, ack_a, owner, an, digit, frame_done);
    end
    req_b = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      idx = (k / 4) % 8;
      vectors++;
      if ({an, digit, frame_done, ack_b} !==
          {~(8'd1 << idx), f[4*idx +: 4], (k == 32), 1'b0}) begin
        errors++;
        $display("FAIL scan_b k=%0d: an=%h digit=%h fd=%b ack_b=%b want an=%h digit=%h fd=%b",
                 k, an, digit, frame_done, ack_b, ~(8'd1 << idx), f[4*idx +: 4], (k == 32));
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    req_a = 1'b1; req_b = 1'b1;
    data_a = 32'hAAAA0001; data_b = 32'hBBBB0002;
    tick();
    vectors++;
    if ({ack_a, ack_b, owner, digit} !== {1'b1, 1'b0, 2'b01, 4'h1}) begin
      errors++;
      $display("FAIL tie_a_wins: ack_a=%b ack_b=%b owner=%b digit=%h want 1 0 01 1",
               ack_a, ack_b, owner, digit);
    end
    req_a = 1'b0;
    for (int k = 1; k < 64; k++) begin
      tick();
      vectors++;
      if ({ack_b, owner} !== {1'b0, 2'b01}) begin
        errors++;
        $display("FAIL b_waits k=%0d: ack_b=%b owner=%b want 0 01", k, ack_b, owner);
      end
    end
    tick();
    vectors++;
    if ({ack_b, frame_done, owner, an, digit} !== {1'b1, 1'b1, 2'b10, 8'hFE, 4'h2}) begin
      errors++;
      $display("FAIL b_after_hold: ack_b=%b fd=%b owner=%b an=%h digit=%h want 1 1 10 fe 2",
               ack_b, frame_done, owner, an, digit);
    end
    req_b = 1'b0;
  endtask

  task automatic test_preempt();
    do_reset();
    req_b = 1'b1; data_b = 32'h0000BEEF; data_a = 32'h00000A11;
    tick();
    req_b = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 10) req_a = 1'b1;
      if (k == 40) req_b = 1'b1;
      if (k == 32) begin
        vectors++;
        if ({frame_done, ack_a, owner} !== {1'b1, 1'b0, 2'b10}) begin
          errors++;
          $display("FAIL no_preempt_first_frame: fd=%b ack_a=%b owner=%b want 1 0 10",
                   frame_done, ack_a, owner);
        end
      end
      if (k == 64) begin
        vectors++;
        if ({frame_done, ack_a, ack_b, owner, digit} !== {1'b1, 1'b1, 1'b0, 2'b01, 4'h1}) begin
          errors++;
          $display("FAIL preempt_a: fd=%b ack_a=%b ack_b=%b owner=%b digit=%h want 1 1 0 01 1",
                   frame_done, ack_a, ack_b, owner, digit);
        end
      end
    end
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_blank();
    logic [31:0] f;
    logic [7:0]  exp_an;
    int idx;
    f = 32'h00000A05;
    do_reset();
    blank_lz = 1'b1; req_a = 1'b1; data_a = f;
    tick();
    req_a = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) tick();
      if (k == 31) blank_lz = 1'b0;
      idx = (k / 4) % 8;
      exp_an = (k < 32 && idx > 2) ? 8'hFF : ~(8'd1 << idx);
      vectors++;
      if (an !== exp_an || (exp_an != 8'hFF && digit !== f[4*idx +: 4])) begin
        errors++;
        $display("FAIL blank k=%0d: an=%h digit=%h want an=%h digit=%h",
                 k, an, digit, exp_an, f[4*idx +: 4]);
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_withdraw_reset();
    do_reset();
    req_a = 1'b1; data_a = 32'h87654321; data_b = 32'h11111111;
    tick();
    req_a = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (k == 10) req_b = 1'b1;
      if (k == 20) req_b = 1'b0;
      vectors++;
      if ({ack_b, owner} !== {1'b0, 2'b01}) begin
        errors++;
        $display("FAIL withdrawn_b k=%0d: ack_b=%b owner=%b want 0 01", k, ack_b, owner);
      end
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({an, digit, owner, ack_a, ack_b, frame_done} !== {8'hFF, 4'd0, 2'b00, 3'b000}) begin
      errors++;
      $display("FAIL mid_reset: an=%h digit=%h owner=%b ack=%b%b fd=%b",
               an, digit, owner, ack_a, ack_b, frame_done);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({an, owner, ack_a, ack_b} !== {8'hFF, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL idle_after_reset: an=%h owner=%b ack=%b%b", an, owner, ack_a, ack_b);
    end
  endtask

  initial begin
    test_reset();
    test_scan_b();
    test_priority();
    test_preempt();
    test_blank();
    test_withdraw_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
